aes256_enc: RTL and testbench
=============================

Name: aes256_enc

Overview:
- Iterative AES-256 block encryptor (FIPS-197) with a simple AXI-style valid/ready register interface.
- A bus master writes four 32-bit plaintext words to the data address, then writes a start bit to the control address.
- The core runs one round per clock, expanding round keys on the fly.
- Once the master is ready, the core presents the 128-bit ciphertext with a valid/ready handshake.

Parameters:
- N, 16, number of bytes in a data block. Fixed; the datapath is defined only for 16.
- KEY, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, default cipher key.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- dataIn_AXI_valid  in  1  write valid from the master.
- masterRd  in  1  master ready to take the write response.
- masterRecDataRd  in  1  master ready to take the ciphertext.
- inpAES  in  [N-1:0][7:0]  write data; only bits [31:0] are used.
- addr  in  1  0 = control register, 1 = data word.
- outAES  out  [N-1:0][7:0]  ciphertext.
- slaveRd  out  1  core ready to accept a write.
- dataOut_AXI_valid  out  1  ciphertext valid.
- slaveValidResp  out  1  write response valid.
- masterSendDataRd  out  1  one-cycle pulse when the ciphertext is consumed.

Behaviour:
- Reset:
  - All outputs 0, plaintext register 0, state IDLE.
  - Reset asserted mid-encryption aborts the operation immediately.
- States: IDLE, RUN, DONE.
- Write accept: occurs on a clock edge when dataIn_AXI_valid && slaveRd.
  - slaveRd = 1 in IDLE and DONE, 0 in RUN.
  - Writes attempted in RUN are not accepted; the master must hold valid.
- Data write (addr=1):
  - The 128-bit plaintext register shifts left 32 bits and takes inpAES[31:0] into bits [31:0].
  - The first of four words therefore ends up in bits [127:96].
  - More than four writes keep only the last four. Fewer than four keep the older contents.
- Control write (addr=0):
  - Bit 0 = start; other bits are ignored.
  - Start in IDLE or DONE: state <- 0x0 ^ plaintext ^ KEY[255:128] (initial AddRoundKey); round counter = 1; go to RUN.
  - Starting from DONE also clears dataOut_AXI_valid.
  - A control write with bit 0 = 0 is acknowledged but has no effect.
- Write response:
  - slaveValidResp rises on the cycle after any accepted write.
  - It stays high until sampled with masterRd = 1, then drops.
  - A new accept while the response is pending keeps it high.
- RUN:
  - One full round per cycle: SubBytes, ShiftRows, MixColumns (skipped in round 14), AddRoundKey.
  - Rounds 1..14 occupy 14 cycles.
  - Round keys:
    - Round 1 uses KEY[127:0].
    - Each later round key is generated from a 256-bit key window per FIPS-197.
    - Even step: RotWord, SubWord, Rcon. Odd step: SubWord only.
    - No stored key-schedule array.
- Latency: outAES updates and dataOut_AXI_valid rises exactly 14 cycles after the start-accept edge; state goes to DONE.
- DONE:
  - outAES is held until the next start.
  - dataOut_AXI_valid is held until a cycle with masterRecDataRd = 1.
  - On that cycle: masterSendDataRd pulses for one cycle, valid drops, state goes to IDLE.
  - If masterRecDataRd is already 1 when valid rises, the handshake completes on the next edge.
- Byte order:
  - Byte 0 of the AES state = inpAES/outAES bits [127:120].
  - Columns are taken MSB-first.

Optional Feature:
- Macro: AES_KEY_WR_EN.
- Defined:
  - Control bit 1 set to 1 makes subsequent addr=1 writes shift into a 256-bit key register instead of the plaintext register.
  - Eight words fill the key register, MSB word first.
  - Control bit 1 set to 0 returns data writes to the plaintext register.
  - The key register resets to KEY.
- Undefined:
  - Control bit 1 is ignored and the key is always the KEY parameter.

Decomposition:
- Package aes256_pkg holds:
  - the 256-entry S-box constant;
  - the Rcon constants;
  - state typedefs;
  - gf_xtime and mix_column functions.
- One sub-module, aes256_round: combinational round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey), instantiated once.

Test Plan:
- Reset check: assert resetn=0 mid-RUN -> all outputs 0, state IDLE; a new run after release produces correct results.
- FIPS vector with default KEY:
  - Stimulus: writes 00112233, 44556677, 8899aabb, ccddeeff (addr=1), then 1 (addr=0).
  - Response: outAES = 8ea2b7ca516745bfeafc49904b496089, dataOut_AXI_valid exactly 14 cycles after the start accept.
- Back-pressure: masterRecDataRd=0 for 5 cycles -> valid and outAES held; masterSendDataRd pulses once when ready rises.
- Write response: masterRd held 0 -> slaveValidResp stays 1 after each write and clears the cycle after masterRd=1.
- Busy: a write during RUN -> not accepted (slaveRd=0); it is accepted after DONE; the result is unchanged.
- With AES_KEY_WR_EN, all-zero key written and plaintext 0 -> outAES = dc95c078a2408989ad48a21492842087.

Source files
------------

// File: rtl/aes256_pkg.sv
// rtl/aes256_pkg.sv - AES-256 constants, state types and GF(2^8) helpers
package aes256_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    typedef logic [127:0] block_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed by (round >> 1); only odd rounds use Rcon, entries 0..6 are needed.
    localparam logic [7:0] RCON [8] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = gf_xtime(a0) ^ gf_xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ gf_xtime(a1) ^ gf_xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ gf_xtime(a2) ^ gf_xtime(a3) ^ a3;
        b3 = gf_xtime(a0) ^ a0 ^ a1 ^ a2 ^ gf_xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes256_round.sv
// rtl/aes256_round.sv - one combinational AES round: SubBytes, ShiftRows, MixColumns (unless last), AddRoundKey
module aes256_round
    import aes256_pkg::*;
(
    input  block_t state_i,
    input  block_t round_key_i,
    input  logic   last_i,
    output block_t state_o
);

    block_t sb, sr, mc;

    // Byte i of the state sits at bits [127-8i -: 8]; byte index = row + 4*column.
    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = SBOX[state_i[127-8*i -: 8]];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
        state_o = (last_i ? sr : mc) ^ round_key_i;
    end

endmodule

// File: rtl/aes256_enc.sv
// rtl/aes256_enc.sv - iterative AES-256 encryptor, one round per clock, on-the-fly key schedule.
// Optional AES_KEY_WR_EN: control bit 1 steers data writes into a writable 256-bit key register.
module aes256_enc
    import aes256_pkg::*;
#(
    parameter int           N   = 16,
    parameter logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dataIn_AXI_valid,
    input  logic              masterRd,
    input  logic              masterRecDataRd,
    input  logic [N-1:0][7:0] inpAES,
    input  logic              addr,
    output logic [N-1:0][7:0] outAES,
    output logic              slaveRd,
    output logic              dataOut_AXI_valid,
    output logic              slaveValidResp,
    output logic              masterSendDataRd
);

    aes_state_e   state_q, state_d;
    block_t       pt_q, pt_d;
    block_t       st_q, st_d;
    block_t       out_q, out_d;
    logic [255:0] kwin_q, kwin_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         valid_q, valid_d;
    logic         resp_q, resp_d;
    logic         send_q, send_d;

    logic [8*N-1:0] in_flat;
    logic [31:0]    wr_word;
    logic           unused_bits;
    logic           wr_acc, data_wr, pt_wr, start, handshake;
    logic [255:0]   key_src;
    block_t         round_out;
    logic [31:0]    rot_w, t_word, nw0, nw1, nw2, nw3;

    assign in_flat     = inpAES;
    assign wr_word     = in_flat[31:0];
    assign unused_bits = ^in_flat[8*N-1:32];

    assign wr_acc    = dataIn_AXI_valid && slaveRd;
    assign data_wr   = wr_acc && addr;
    assign start     = wr_acc && !addr && wr_word[0];
    assign handshake = (state_q == DONE) && valid_q && masterRecDataRd;

`ifdef AES_KEY_WR_EN
    logic [255:0] key_q, key_d;
    logic         key_sel_q, key_sel_d;

    always_comb begin
        key_d     = key_q;
        key_sel_d = key_sel_q;
        if (wr_acc && !addr) begin
            key_sel_d = wr_word[1];
        end
        if (data_wr && key_sel_q) begin
            key_d = {key_q[223:0], wr_word};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q     <= KEY;
            key_sel_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            key_sel_q <= key_sel_d;
        end
    end

    assign key_src = key_q;
    assign pt_wr   = data_wr && !key_sel_q;
`else
    assign key_src = KEY;
    assign pt_wr   = data_wr;
`endif

    aes256_round u_round (
        .state_i    (st_q),
        .round_key_i(kwin_q[127:0]),
        .last_i     (rnd_q == 4'd14),
        .state_o    (round_out)
    );

    // The window holds the previous and current round keys; odd rounds produce an even (Rcon) step.
    always_comb begin
        rot_w  = {kwin_q[23:0], kwin_q[31:24]};
        t_word = rnd_q[0] ? (sub_word(rot_w) ^ {RCON[rnd_q[3:1]], 24'h0}) : sub_word(kwin_q[31:0]);
        nw0    = kwin_q[255:224] ^ t_word;
        nw1    = kwin_q[223:192] ^ nw0;
        nw2    = kwin_q[191:160] ^ nw1;
        nw3    = kwin_q[159:128] ^ nw2;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (rnd_q == 4'd14) state_d = DONE;
            DONE: begin
                if (start) begin
                    state_d = RUN;
                end else if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // slaveRd is gated by reset so every output reads 0 while resetn is low.
    always_comb begin
        slaveRd = resetn && (state_q != RUN);
    end

    always_comb begin
        pt_d    = pt_q;
        st_d    = st_q;
        out_d   = out_q;
        kwin_d  = kwin_q;
        rnd_d   = rnd_q;
        valid_d = valid_q;
        resp_d  = resp_q;
        send_d  = 1'b0;
        if (pt_wr) begin
            pt_d = {pt_q[95:0], wr_word};
        end
        if (wr_acc) begin
            resp_d = 1'b1;
        end else if (resp_q && masterRd) begin
            resp_d = 1'b0;
        end
        if (handshake) begin
            valid_d = 1'b0;
            send_d  = 1'b1;
        end
        if (start) begin
            st_d    = pt_q ^ key_src[255:128];
            kwin_d  = key_src;
            rnd_d   = 4'd1;
            valid_d = 1'b0;
        end else if (state_q == RUN) begin
            st_d   = round_out;
            kwin_d = {kwin_q[127:0], nw0, nw1, nw2, nw3};
            rnd_d  = rnd_q + 4'd1;
            if (rnd_q == 4'd14) begin
                out_d   = round_out;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pt_q    <= '0;
            st_q    <= '0;
            out_q   <= '0;
            kwin_q  <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            resp_q  <= 1'b0;
            send_q  <= 1'b0;
        end else begin
            pt_q    <= pt_d;
            st_q    <= st_d;
            out_q   <= out_d;
            kwin_q  <= kwin_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            resp_q  <= resp_d;
            send_q  <= send_d;
        end
    end

    assign outAES            = out_q;
    assign dataOut_AXI_valid = valid_q;
    assign slaveValidResp    = resp_q;
    assign masterSendDataRd  = send_q;

endmodule

// File: tb/tb_aes256_enc.sv
// tb/tb_aes256_enc.sv - vector-table and randomized bench for aes256_enc against a byte-level AES model
module tb_aes256_enc;

    localparam logic [255:0] TB_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic              clk = 1'b0;
    logic              resetn;
    logic              dataIn_AXI_valid;
    logic              masterRd;
    logic              masterRecDataRd;
    logic [15:0][7:0]  inpAES;
    logic              addr;
    logic [15:0][7:0]  outAES;
    logic              slaveRd;
    logic              dataOut_AXI_valid;
    logic              slaveValidResp;
    logic              masterSendDataRd;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb [256];
    logic [31:0] wq [$];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    vec_t tbl [6];

    aes256_enc #(.N(16), .KEY(TB_KEY)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .dataIn_AXI_valid (dataIn_AXI_valid),
        .masterRd         (masterRd),
        .masterRecDataRd  (masterRecDataRd),
        .inpAES           (inpAES),
        .addr             (addr),
        .outAES           (outAES),
        .slaveRd          (slaveRd),
        .dataOut_AXI_valid(dataOut_AXI_valid),
        .slaveValidResp   (slaveValidResp),
        .masterSendDataRd (masterSendDataRd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                for (int rr = 0; rr < 4; rr++) begin
                    if (r < 14)
                        s[4*c+rr] = gmul(t[4*c+rr], 8'h02) ^ gmul(t[4*c+(rr+1)%4], 8'h03)
                                  ^ t[4*c+(rr+2)%4] ^ t[4*c+(rr+3)%4];
                    else
                        s[4*c+rr] = t[4*c+rr];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Plaintext register = the last four data words written since reset, zero-filled.
    function automatic logic [127:0] cur_pt();
        logic [127:0] p;
        int           n;
        int           first;
        p = '0;
        n = wq.size();
        first = (n > 4) ? n - 4 : 0;
        for (int i = first; i < n; i++) p = {p[95:0], wq[i]};
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic a, input logic [31:0] d);
        int n;
        n = 0;
        dataIn_AXI_valid = 1'b1;
        addr = a;
        inpAES = {96'h0, d};
        while (!slaveRd && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("write_accept_timeout", 128'(n), 128'd0);
        tick();
        dataIn_AXI_valid = 1'b0;
        inpAES = '0;
    endtask

    task automatic load_word(input logic [31:0] d);
        bus_write(1'b1, d);
        wq.push_back(d);
    endtask

    task automatic load_block(input logic [127:0] pt);
        for (int i = 0; i < 4; i++) load_word(pt[127-32*i -: 32]);
    endtask

    task automatic run_block(input logic [127:0] exp, input int hold);
        int n;
        if (hold < 0) masterRecDataRd = 1'b1;
        bus_write(1'b0, 32'h1);
        n = 0;
        while (!dataOut_AXI_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 128'(n), 128'd14);
        chk("ciphertext", outAES, exp);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", 128'(dataOut_AXI_valid), 128'd1);
            chk("hold_data", outAES, exp);
            chk("hold_no_pulse", 128'(masterSendDataRd), 128'd0);
        end
        masterRecDataRd = 1'b1;
        tick();
        chk("consume_pulse", 128'(masterSendDataRd), 128'd1);
        chk("consume_valid_drop", 128'(dataOut_AXI_valid), 128'd0);
        masterRecDataRd = 1'b0;
        tick();
        chk("pulse_single", 128'(masterSendDataRd), 128'd0);
    endtask

    initial begin
        int          n;
        logic [7:0]  inv;
        logic [31:0] w;
        logic [127:0] exp;

        resetn = 1'b0;
        dataIn_AXI_valid = 1'b0;
        masterRd = 1'b1;
        masterRecDataRd = 1'b0;
        inpAES = '0;
        addr = 1'b0;

        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sb[v] = affine(inv);
        end

        tbl[0] = '{pt: 128'h00112233445566778899aabbccddeeff, ct: 128'h8ea2b7ca516745bfeafc49904b496089, hold: 5};
        for (int i = 1; i < 6; i++) begin
            tbl[i].pt   = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].ct   = aes_ref(TB_KEY, tbl[i].pt);
            tbl[i].hold = i - 2;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", outAES, 128'd0);
        chk("reset_valid", 128'(dataOut_AXI_valid), 128'd0);
        chk("reset_resp", 128'(slaveValidResp), 128'd0);
        chk("reset_send", 128'(masterSendDataRd), 128'd0);
        chk("reset_slaverd", 128'(slaveRd), 128'd0);
        resetn = 1'b1;
        tick();
        chk("idle_slaverd", 128'(slaveRd), 128'd1);

        for (int i = 0; i < 6; i++) begin
            load_block(tbl[i].pt);
            run_block(tbl[i].ct, tbl[i].hold);
        end

        masterRd = 1'b0;
        w = $urandom;
        load_word(w);
        chk("resp_rise", 128'(slaveValidResp), 128'd1);
        repeat (3) begin
            tick();
            chk("resp_held", 128'(slaveValidResp), 128'd1);
        end
        w = $urandom;
        load_word(w);
        chk("resp_second", 128'(slaveValidResp), 128'd1);
        masterRd = 1'b1;
        tick();
        chk("resp_clear", 128'(slaveValidResp), 128'd0);

        run_block(aes_ref(TB_KEY, cur_pt()), 0);

        for (int i = 0; i < 6; i++) load_word($urandom);
        run_block(aes_ref(TB_KEY, cur_pt()), 1);

        load_block({$urandom, $urandom, $urandom, $urandom});
        exp = aes_ref(TB_KEY, cur_pt());
        bus_write(1'b0, 32'h1);
        repeat (3) tick();
        chk("busy_slaverd", 128'(slaveRd), 128'd0);
        w = $urandom;
        dataIn_AXI_valid = 1'b1;
        addr = 1'b1;
        inpAES = {96'h0, w};
        n = 3;
        while (!slaveRd && n < 40) begin
            tick();
            n++;
        end
        chk("busy_accept_cycle", 128'(n), 128'd14);
        tick();
        dataIn_AXI_valid = 1'b0;
        wq.push_back(w);
        chk("busy_result", outAES, exp);
        chk("busy_valid", 128'(dataOut_AXI_valid), 128'd1);
        masterRecDataRd = 1'b1;
        tick();
        chk("busy_pulse", 128'(masterSendDataRd), 128'd1);
        masterRecDataRd = 1'b0;
        tick();

        load_block({$urandom, $urandom, $urandom, $urandom});
        bus_write(1'b0, 32'h1);
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        chk("abort_out", outAES, 128'd0);
        chk("abort_valid", 128'(dataOut_AXI_valid), 128'd0);
        chk("abort_resp", 128'(slaveValidResp), 128'd0);
        chk("abort_send", 128'(masterSendDataRd), 128'd0);
        chk("abort_slaverd", 128'(slaveRd), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        chk("abort_idle", 128'(slaveRd), 128'd1);
        wq.delete();
        run_block(aes_ref(TB_KEY, 128'd0), 0);
        load_block({$urandom, $urandom, $urandom, $urandom});
        run_block(aes_ref(TB_KEY, cur_pt()), 2);

`ifdef AES_KEY_WR_EN
        bus_write(1'b0, 32'h2);
        for (int i = 0; i < 8; i++) bus_write(1'b1, 32'h0);
        bus_write(1'b0, 32'h0);
        load_block(128'd0);
        run_block(128'hdc95c078a2408989ad48a21492842087, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
